// File: rtl/note_sequencer.sv
// Eight-step note sequencer: plays an 8 x 4-bit pattern of note codes, one step every BEAT_TICKS cycles.
// Define SEQ_LOOP_EN to loop the pattern forever; when it is undefined, one pass plays and then done pulses.
module note_sequencer #(
    parameter int unsigned BEAT_TICKS = 50000000,
    parameter int          TONE_W     = 26
) (
    input  logic              clock,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_note,
    output logic [TONE_W-1:0] half_period,
    output logic              tone_en,
    output logic [2:0]        step_idx,
    output logic              step_strobe,
    output logic [7:0]        note_onehot,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    localparam logic [31:0] PLAY_LAST = 32'(BEAT_TICKS - 2);

    state_t      state, state_nxt;
    logic [2:0]  ptr;
    logic [31:0] beat_cnt;
    logic [3:0]  pattern [8];
    logic [3:0]  cur_note;
    logic        beat_end, wrap_end;
    logic        fetch_load, done_set, silence;

    function automatic logic [TONE_W-1:0] tone_of(input logic [3:0] c);
        case (c)
            4'd1:    tone_of = TONE_W'(305810);
            4'd2:    tone_of = TONE_W'(272479);
            4'd3:    tone_of = TONE_W'(242718);
            4'd4:    tone_of = TONE_W'(229042);
            4'd5:    tone_of = TONE_W'(204081);
            4'd6:    tone_of = TONE_W'(181818);
            4'd7:    tone_of = TONE_W'(161969);
            4'd8:    tone_of = TONE_W'(152905);
            default: tone_of = '0;
        endcase
    endfunction

    function automatic logic is_note(input logic [3:0] c);
        is_note = (c >= 4'd1) && (c <= 4'd8);
    endfunction

    assign cur_note = pattern[ptr];
    assign beat_end = (state == PLAY) && (beat_cnt == PLAY_LAST);

`ifdef SEQ_LOOP_EN
    assign wrap_end = 1'b0;
`else
    // The FETCH slot after step 7 ends the pass, so step 7 sounds a full beat before done.
    logic fin;
    always_ff @(posedge clock or posedge RST) begin
        if (RST) fin <= 1'b0;
        else     fin <= beat_end && (ptr == 3'd7) && !stop && !start;
    end
    assign wrap_end = fin && (state == FETCH);
`endif

    always_ff @(posedge clock or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = FETCH;
        else begin
            case (state)
                FETCH:   state_nxt = wrap_end ? IDLE : PLAY;
                PLAY:    if (beat_end) state_nxt = FETCH;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        fetch_load = (state == FETCH) && !wrap_end && !stop && !start;
        done_set   = wrap_end && !stop && !start;
        silence    = stop || done_set;
    end

    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            ptr         <= '0;
            beat_cnt    <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            note_onehot <= '0;
            done        <= 1'b0;
        end else begin
            beat_cnt    <= (state == PLAY) ? beat_cnt + 32'd1 : '0;
            step_strobe <= fetch_load;
            done        <= done_set;
            if (start && !stop)
                ptr <= '0;
            else if (beat_end && !stop)
                ptr <= ptr + 3'd1;
            if (fetch_load) begin
                half_period <= tone_of(cur_note);
                tone_en     <= is_note(cur_note);
                note_onehot <= is_note(cur_note) ? (8'h80 >> (cur_note - 4'd1)) : 8'h00;
                step_idx    <= ptr;
            end else if (silence) begin
                half_period <= '0;
                tone_en     <= 1'b0;
                note_onehot <= '0;
            end
        end
    end

    // A write landing on the slot being fetched is seen only on that slot's next fetch.
    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) pattern[i] <= 4'(i + 1);
        end else if (wr_en) begin
            pattern[wr_addr] <= wr_note;
        end
    end

endmodule
